// File: rtl/param_matmul_pkg.sv
// Shared types and elaboration-time helpers for the parameterised matrix multiplier.
package param_matmul_pkg;

    typedef enum logic [1:0] {
        LOAD_W,
        LOAD_X,
        MAC,
        EMIT
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Accumulator wide enough that a sum of N full-scale products never wraps.
    function automatic int calc_accw(input int n, input int dw);
        return 2 * dw + clog2(n);
    endfunction

endpackage

// File: rtl/param_matmul_mac.sv
// Multiply-accumulate slice: product of two DW-bit operands extended to ACCW and summed.
module mac_unit #(
    parameter int DW     = 4,
    parameter int ACCW   = 10,
    parameter int SIGNED = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            en,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [ACCW-1:0] acc
);

    logic [2*DW-1:0] a_ext;
    logic [2*DW-1:0] b_ext;
    logic [2*DW-1:0] prod;
    logic [ACCW-1:0] prod_ext;
    logic [ACCW-1:0] acc_reg;

    // Operands are widened to the product width first so the low 2*DW bits
    // of the multiply are exact for both signed and unsigned interpretation.
    generate
        if (SIGNED != 0) begin : g_signed
            assign a_ext    = {{DW{a[DW-1]}}, a};
            assign b_ext    = {{DW{b[DW-1]}}, b};
            assign prod_ext = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
        end else begin : g_unsigned
            assign a_ext    = {{DW{1'b0}}, a};
            assign b_ext    = {{DW{1'b0}}, b};
            assign prod_ext = {{(ACCW-2*DW){1'b0}}, prod};
        end
    endgenerate

    assign prod = a_ext * b_ext;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_reg + prod_ext;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/param_matmul.sv
// NxN matrix multiplier: streams in W then X row-major, emits C = W*X row-major,
// one element per N accumulate cycles.
module param_matmul
    import param_matmul_pkg::*;
#(
    parameter int N      = 3,
    parameter int DW     = 4,
    parameter int SIGNED = 0,
    localparam int ACCW  = calc_accw(N, DW)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    output logic            in_ready,
    output logic            out_valid,
    output logic [ACCW-1:0] out_data,
    input  logic            out_ready,
    output logic            out_last,
    output logic            busy
);

    localparam int CW = clog2(N);
    localparam int AW = clog2(N * N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t          state_reg, state_next;
    logic [CW-1:0]   row_reg, col_reg;
    logic [CW-1:0]   i_reg, j_reg, k_reg;
    logic [DW-1:0]   w_mem [N*N];
    logic [DW-1:0]   x_mem [N*N];
    logic            load_last;
    logic            mac_en;
    logic            mac_clear;
    logic [ACCW-1:0] acc;

    function automatic logic [AW-1:0] addr(input logic [CW-1:0] row, input logic [CW-1:0] col);
        return AW'(row) * AW'(N) + AW'(col);
    endfunction

    function automatic logic [CW-1:0] inc_wrap(input logic [CW-1:0] value);
        return (value == LAST) ? '0 : value + 1'b1;
    endfunction

    assign load_last = (row_reg == LAST) && (col_reg == LAST);

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        mac_en     = 1'b0;
        mac_clear  = 1'b0;
        busy       = (state_reg != LOAD_W);
        case (state_reg)
            LOAD_W: begin
                in_ready = 1'b1;
                if (in_valid && load_last) state_next = LOAD_X;
            end
            LOAD_X: begin
                in_ready = 1'b1;
                if (in_valid && load_last) state_next = MAC;
            end
            MAC: begin
                mac_en = 1'b1;
                if (k_reg == LAST) state_next = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_last  = (i_reg == LAST) && (j_reg == LAST);
                if (out_ready) begin
                    mac_clear  = 1'b1;
                    state_next = out_last ? LOAD_W : MAC;
                end
            end
            default: state_next = LOAD_W;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= LOAD_W;
            row_reg   <= '0;
            col_reg   <= '0;
            i_reg     <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                LOAD_W, LOAD_X: begin
                    if (in_valid) begin
                        col_reg <= inc_wrap(col_reg);
                        if (col_reg == LAST) row_reg <= inc_wrap(row_reg);
                    end
                end
                MAC: k_reg <= inc_wrap(k_reg);
                // After C[N-1][N-1] both indices wrap back to zero on their own.
                EMIT: begin
                    if (out_ready) begin
                        j_reg <= inc_wrap(j_reg);
                        if (j_reg == LAST) i_reg <= inc_wrap(i_reg);
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand storage carries no reset; it is always fully rewritten before use.
    always_ff @(posedge clk) begin
        if (state_reg == LOAD_W && in_valid) w_mem[addr(row_reg, col_reg)] <= in_data;
        if (state_reg == LOAD_X && in_valid) x_mem[addr(row_reg, col_reg)] <= in_data;
    end

    mac_unit #(
        .DW     (DW),
        .ACCW   (ACCW),
        .SIGNED (SIGNED)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clear (mac_clear),
        .en    (mac_en),
        .a     (w_mem[addr(i_reg, k_reg)]),
        .b     (x_mem[addr(k_reg, j_reg)]),
        .acc   (acc)
    );

    assign out_data = acc;

endmodule

// File: tb/tb_param_matmul.sv
// Directed bench for param_matmul: unsigned and signed instances fed in lockstep.
module tb_param_matmul;

    localparam int N    = 3;
    localparam int DW   = 4;
    localparam int ACCW = 10;
    localparam int NN   = N * N;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            out_ready;
    logic            sel;

    logic            u_in_ready, u_out_valid, u_out_last, u_busy;
    logic [ACCW-1:0] u_out_data;
    logic            s_in_ready, s_out_valid, s_out_last, s_busy;
    logic [ACCW-1:0] s_out_data;

    int checks = 0;
    int errors = 0;

    int m_id  [NN] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    int m_seq [NN] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int m_rev [NN] = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
    int m_prod[NN] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    int m_15  [NN] = '{default: 15};
    int m_675 [NN] = '{default: 675};
    int m_n8  [NN] = '{default: -8};
    int m_p7  [NN] = '{default: 7};
    int m_192 [NN] = '{default: 192};
    int m_n168[NN] = '{default: -168};

    always #5 clk = ~clk;

    param_matmul #(.N(N), .DW(DW), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(u_in_ready), .out_valid(u_out_valid), .out_data(u_out_data),
        .out_ready(out_ready), .out_last(u_out_last), .busy(u_busy)
    );

    param_matmul #(.N(N), .DW(DW), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
        .out_ready(out_ready), .out_last(s_out_last), .busy(s_busy)
    );

    function automatic logic [31:0] obs_ready();
        return {31'b0, sel ? s_in_ready : u_in_ready};
    endfunction
    function automatic logic [31:0] obs_valid();
        return {31'b0, sel ? s_out_valid : u_out_valid};
    endfunction
    function automatic logic [31:0] obs_last();
        return {31'b0, sel ? s_out_last : u_out_last};
    endfunction
    function automatic logic [31:0] obs_busy();
        return {31'b0, sel ? s_busy : u_busy};
    endfunction
    function automatic logic [31:0] obs_data();
        return {22'b0, sel ? s_out_data : u_out_data};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load(input int w[NN], input int x[NN], input bit gaps);
        for (int e = 0; e < 2 * NN; e++) begin
            if (gaps && (e % 3) != 1) begin
                in_valid = 1'b0;
                in_data  = 4'($urandom);
                repeat (1 + (e % 2)) begin
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_data  = (e < NN) ? 4'(w[e]) : 4'(x[e - NN]);
            check("in_ready_load", obs_ready(), 32'd1);
            @(posedge clk); #1;
        end
        // With gaps enabled, in_valid stays high into MAC/EMIT as stray input.
        in_valid = gaps;
        in_data  = 4'hF;
    endtask

    task automatic collect(input int exp[NN], input bit bp, input int rst_at);
        int waited;
        for (int r = 0; r < NN; r++) begin
            if (r == rst_at) begin
                @(posedge clk); #1;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                in_valid = 1'b0;
                check("rst_in_ready", obs_ready(), 32'd1);
                check("rst_out_valid", obs_valid(), 32'd0);
                check("rst_busy", obs_busy(), 32'd0);
                repeat (4) begin
                    @(posedge clk); #1;
                    check("rst_no_valid", obs_valid(), 32'd0);
                end
                return;
            end
            waited = 0;
            while (obs_valid() != 32'd1 && waited < 50) begin
                @(posedge clk); #1;
                waited++;
            end
            check("latency", 32'(waited), 32'(N));
            check("out_data", obs_data(), {22'b0, 10'(exp[r])});
            check("out_last", obs_last(), (r == NN - 1) ? 32'd1 : 32'd0);
            check("emit_in_ready", obs_ready(), 32'd0);
            if (bp && r == 0) begin
                out_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                    check("bp_valid", obs_valid(), 32'd1);
                    check("bp_data", obs_data(), {22'b0, 10'(exp[r])});
                    check("bp_in_ready", obs_ready(), 32'd0);
                end
                out_ready = 1'b1;
            end
            if (r == NN - 1) in_valid = 1'b0;
            $display("result %0d data=%0d last=%0d", r, obs_data(), obs_last());
            @(posedge clk); #1;
        end
        check("done_busy", obs_busy(), 32'd0);
        check("done_valid", obs_valid(), 32'd0);
        check("done_in_ready", obs_ready(), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        sel       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            sel = d[0];
            check("reset_in_ready", obs_ready(), 32'd1);
            check("reset_out_valid", obs_valid(), 32'd0);
            check("reset_out_last", obs_last(), 32'd0);
            check("reset_busy", obs_busy(), 32'd0);
            check("reset_out_data", obs_data(), 32'd0);
        end

        sel = 1'b0;
        load(m_id, m_seq, 1'b0);
        collect(m_seq, 1'b0, -1);
        load(m_15, m_15, 1'b0);
        collect(m_675, 1'b0, -1);

        sel = 1'b1;
        load(m_n8, m_n8, 1'b0);
        collect(m_192, 1'b0, -1);
        load(m_n8, m_p7, 1'b0);
        collect(m_n168, 1'b0, -1);

        sel = 1'b0;
        load(m_seq, m_rev, 1'b0);
        collect(m_prod, 1'b1, -1);
        load(m_seq, m_rev, 1'b0);
        collect(m_prod, 1'b0, 3);
        load(m_seq, m_rev, 1'b0);
        collect(m_prod, 1'b0, -1);
        load(m_seq, m_rev, 1'b1);
        collect(m_prod, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
